// File: rtl/uart_cmd_hub.sv
// Multi-channel UART command hub: per-channel RX FIFO, echo FSM, LED toggles.
// Define UART_CMD_HUB_ECHO_EN to enable echo; otherwise FIFOs drain one byte/cycle.
module uart_cmd_hub #(
   parameter int         CHANNELS   = 2,
   parameter int         LEDS       = 4,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] CMD_BASE   = 8'h31
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS-1:0]   rx_valid,
   input  logic [8*CHANNELS-1:0] rx_data,
   input  logic [CHANNELS-1:0]   tx_busy,
   output logic [CHANNELS-1:0]   tx_send,
   output logic [8*CHANNELS-1:0] tx_data,
   output logic [LEDS-1:0]       led,
   output logic [CHANNELS-1:0]   overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_CMD_HUB_ECHO_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_WAIT
   } state_t;
`endif

   logic [LEDS-1:0] ch_mask [CHANNELS];
   logic [LEDS-1:0] mask_all;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [7:0]  mem [FIFO_DEPTH];
      logic [AW:0] wr_ptr;
      logic [AW:0] rd_ptr;
      logic        empty;
      logic        full;
      logic        push;
      logic        pop;
      logic [7:0]  head;
      logic [LEDS-1:0] m;
      logic        ovf;

      assign empty = (wr_ptr == rd_ptr);
      assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      // A pop in the same cycle frees the slot for a push into a full FIFO
      assign push  = rx_valid[i] && (!full || pop);
      assign head  = mem[rd_ptr[AW-1:0]];

      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr[AW-1:0]] <= rx_data[8*i+7 -: 8];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (rx_valid[i] && full && !pop) ovf <= 1'b1;
         end
      end

      assign overflow[i] = ovf;

      // 9-bit compare so CMD_BASE+k never wraps past 8'hFF
      always_comb begin
         m = '0;
         for (int k = 0; k < LEDS; k++) begin
            if (pop && ({1'b0, head} == 9'({1'b0, CMD_BASE} + k)))
               m[k] = 1'b1;
         end
      end

      assign ch_mask[i] = m;

`ifdef UART_CMD_HUB_ECHO_EN
      state_t     state;
      state_t     state_nxt;
      logic       send_r;
      logic [7:0] data_r;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) state <= S_IDLE;
         else     state <= state_nxt;
      end

      always_comb begin
         state_nxt = state;
         pop       = 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!empty && !tx_busy[i]) begin
                  pop       = 1'b1;
                  state_nxt = S_HOLD;
               end
            end
            // UART needs a cycle before it raises busy
            S_HOLD: state_nxt = S_WAIT;
            S_WAIT: begin
               if (!tx_busy[i]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            send_r <= 1'b0;
            data_r <= '0;
         end else begin
            send_r <= pop;
            if (pop) data_r <= head;
         end
      end

      assign tx_send[i]          = send_r;
      assign tx_data[8*i+7 -: 8] = data_r;
`else
      assign pop = !empty;
`endif
   end

`ifndef UART_CMD_HUB_ECHO_EN
   logic unused_busy;

   assign unused_busy = ^tx_busy;
   assign tx_send     = '0;
   assign tx_data     = '0;
`endif

   // Same-cycle toggles of one LED from two channels cancel
   always_comb begin
      mask_all = '0;
      for (int c = 0; c < CHANNELS; c++) mask_all = mask_all ^ ch_mask[c];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) led <= '0;
      else     led <= led ^ mask_all;
   end

endmodule

// File: tb/tb_uart_cmd_hub.sv
// Randomised scoreboard bench for uart_cmd_hub against a queue-based model.
// Follows UART_CMD_HUB_ECHO_EN the same way as the design.
module tb_uart_cmd_hub;

   localparam int CH    = 2;
   localparam int LEDS  = 4;
   localparam int DEPTH = 4;
   localparam logic [7:0] BASE = 8'h31;

`ifdef UART_CMD_HUB_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [CH-1:0]   rx_valid = '0;
   logic [8*CH-1:0] rx_data = '0;
   logic [CH-1:0]   tx_busy = '0;
   logic [CH-1:0]   tx_send;
   logic [8*CH-1:0] tx_data;
   logic [LEDS-1:0] led;
   logic [CH-1:0]   overflow;

   int tests = 0;
   int fails = 0;

   uart_cmd_hub #(
      .CHANNELS(CH), .LEDS(LEDS), .FIFO_DEPTH(DEPTH), .CMD_BASE(BASE)
   ) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_send(tx_send), .tx_data(tx_data),
      .led(led), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [LEDS-1:0] led;
      logic [CH-1:0]   ovf;
      logic [CH-1:0]   send;
      logic [8*CH-1:0] data;
   } exp_t;

   exp_t exq[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte queues, a per-channel echo phase, LED state
   logic [7:0]      mq [CH][$];
   int              ph [CH];
   logic [7:0]      last [CH];
   logic [CH-1:0]   m_ovf;
   logic [LEDS-1:0] m_led;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int c = 0; c < CH; c++) begin
               mq[c].delete();
               ph[c]   = 0;
               last[c] = '0;
            end
            m_ovf = '0;
            m_led = '0;
            exq.delete();
         end else begin
            exp_t e;
            logic [LEDS-1:0] mask;
            mask   = '0;
            e.send = '0;
            for (int c = 0; c < CH; c++) begin
               bit   pop;
               logic [7:0] b;
               if (ECHO) pop = (ph[c] == 0) && (mq[c].size() > 0) && !tx_busy[c];
               else      pop = (mq[c].size() > 0);
               if (pop) begin
                  b = mq[c].pop_front();
                  if (b >= BASE && int'(b) < int'(BASE) + LEDS)
                     mask = mask ^ (LEDS'(1) << (b - BASE));
                  if (ECHO) begin
                     last[c]   = b;
                     e.send[c] = 1'b1;
                  end
               end
               // phase 0: ready, 1: mandatory gap cycle, 2: until busy low
               if (pop)                       ph[c] = 1;
               else if (ph[c] == 1)           ph[c] = 2;
               else if (ph[c] == 2 && !tx_busy[c]) ph[c] = 0;
               if (rx_valid[c]) begin
                  if (mq[c].size() < DEPTH) mq[c].push_back(rx_data[8*c+7 -: 8]);
                  else m_ovf[c] = 1'b1;
               end
            end
            m_led = m_led ^ mask;
            e.led = m_led;
            e.ovf = m_ovf;
            for (int c = 0; c < CH; c++) e.data[8*c+7 -: 8] = last[c];
            exq.push_back(e);
         end
      end
   end

   // Monitor: every cycle the DUT presents registered outputs
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_outputs", {tx_send, tx_data, led, overflow}, '0);
         end else if (exq.size() == 0) begin
            chk("scoreboard_empty", 32'(exq.size()), 32'd1);
         end else begin
            exp_t e;
            e = exq.pop_front();
            chk("led", 32'(led), 32'(e.led));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("tx_send", 32'(tx_send), 32'(e.send));
            chk("tx_data", 32'(tx_data), 32'(e.data));
         end
      end
   end

   task automatic drive(input logic [CH-1:0] v, input logic [7:0] d0,
                        input logic [7:0] d1, input logic [CH-1:0] b);
      rx_valid = v;
      rx_data  = {d1, d0};
      tx_busy  = b;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic [CH-1:0] b);
      for (int i = 0; i < n; i++) drive('0, 8'h00, 8'h00, b);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("async_rst", {tx_send, tx_data, led, overflow}, '0);
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b0;
   endtask

   logic [7:0] pick [10];

   initial begin
      pick = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h41, 8'hFF, 8'h00, 8'h36};
      @(negedge clk); #1;
      @(negedge clk); #1;
      rst = 1'b0;

      drive(2'b01, 8'h31, 8'h00, 2'b00);
      idle(4, 2'b00);
      chk("led_first_31", 32'(led), 32'h1);
      drive(2'b01, 8'h31, 8'h00, 2'b00);
      idle(4, 2'b00);
      chk("led_second_31", 32'(led), 32'h0);

      drive(2'b10, 8'h00, 8'h41, 2'b00);
      idle(4, 2'b00);
      drive(2'b10, 8'h00, 8'h35, 2'b00);
      idle(4, 2'b00);
      chk("led_non_cmd", 32'(led), 32'h0);

      drive(2'b11, 8'h32, 8'h32, 2'b00);
      idle(4, 2'b00);
      chk("led_cancel", 32'(led), 32'h0);
      drive(2'b11, 8'h32, 8'h33, 2'b00);
      idle(4, 2'b00);
      chk("led_two_ch", 32'(led), 32'h6);

      for (int i = 0; i < 5; i++) drive(2'b01, 8'hA0 + 8'(i), 8'h00, 2'b01);
      idle(1, 2'b01);
      chk("overflow_5th", 32'(overflow), ECHO ? 32'h1 : 32'h0);
      idle(20, 2'b00);

      for (int i = 0; i < 3; i++) drive(2'b01, 8'h31, 8'h00, 2'b11);
      do_reset();
      idle(10, 2'b00);
      chk("no_echo_after_rst", 32'(led), 32'h0);

      drive(2'b01, 8'h31, 8'h00, 2'b00);
      drive(2'b01, 8'h34, 8'h00, 2'b00);
      idle(4, 2'b00);
      chk("led_1001", 32'(led), 32'h9);

      for (int n = 0; n < 3000; n++) begin
         logic [CH-1:0] v;
         logic [CH-1:0] b;
         if ($urandom_range(0, 599) == 0) do_reset();
         for (int c = 0; c < CH; c++) begin
            v[c] = ($urandom_range(0, 99) < 45);
            b[c] = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 30 : 75));
         end
         drive(v, pick[$urandom_range(0, 9)], pick[$urandom_range(0, 9)], b);
      end
      idle(30, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
